// File: rtl/aes_128_in_packer.sv
// aes_128_in_packer: packs 32-bit words into 128-bit key/data blocks and queues them for the AES core
//   clk, rst_n         clock, asynchronous active-low reset
//   s_data/s_key       input word and its block type (1 = key, 0 = data); word 0 fixes the type
//   s_valid/s_ready    input handshake; s_ready drops only when the 4th word would overflow the buffer
//   s_flush            drops the partially assembled block (and any word offered with it)
//   m_data/m_key       head block of the DEPTH-entry buffer, word 0 in [127:96]
//   m_valid/m_ready    output handshake
//   level              number of stored blocks
//   mix_err            sticky: a key/data mix was seen inside one block
module aes_128_in_packer #(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [31:0]                  s_data,
  input  logic                         s_key,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic                         s_flush,
  output logic [127:0]                 m_data,
  output logic                         m_key,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         mix_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [1:0]    wcnt;
  logic          blk_key;
  logic [95:0]   part;
  logic [127:0]  mem_d [DEPTH];
  logic          mem_k [DEPTH];
  logic [PW-1:0] wp, rp;
  logic          acc, match, push, pop;
  assign s_ready = (wcnt != 2'd3) || (level < FULL);
  assign acc     = s_valid && s_ready && !s_flush;
  assign match   = (wcnt == 2'd0) || (s_key == blk_key);
  assign push    = acc && match && (wcnt == 2'd3);
  assign m_valid = level != '0;
  assign pop     = m_valid && m_ready;
  // head is read straight from storage; gating with m_valid yields zeros while reset is held
  assign m_data  = m_valid ? mem_d[rp] : '0;
  assign m_key   = m_valid ? mem_k[rp] : 1'b0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt    <= '0;
      wp      <= '0;
      rp      <= '0;
      level   <= '0;
      mix_err <= 1'b0;
    end else begin
      if (s_flush || (acc && !match)) wcnt <= '0;
      else if (acc) wcnt <= wcnt + 2'd1;
      if (acc && !match) mix_err <= 1'b1;
      if (push) wp <= (wp == LAST) ? '0 : wp + 1'b1;
      if (pop) rp <= (rp == LAST) ? '0 : rp + 1'b1;
      if (push && !pop) level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end
  // words 0..2 shift into part; word 3 completes the block directly into storage
  always_ff @(posedge clk) begin
    if (acc && wcnt == 2'd0) blk_key <= s_key;
    if (acc && wcnt != 2'd3) part <= {part[63:0], s_data};
    if (push) begin
      mem_d[wp] <= {part, s_data};
      mem_k[wp] <= blk_key;
    end
  end
endmodule

// File: doc/aes_128_in_packer.md
AES_128_IN_PACKER -- requirements
Module: aes_128_in_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of 128-bit block entries in the output buffer (legal range 2..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port s_data, input, 32 bits: input word.
REQ-005 SHALL have port s_key, input, 1 bit: 1 = word belongs to a key block, 0 = word belongs to a data block.
REQ-006 SHALL have port s_valid, input, 1 bit: input word valid.
REQ-007 SHALL have port s_ready, output, 1 bit: packer accepts the word this cycle.
REQ-008 SHALL have port s_flush, input, 1 bit: discard the partially assembled block.
REQ-009 SHALL have port m_data, output, 128 bits: assembled block at the buffer head.
REQ-010 SHALL have port m_key, output, 1 bit: block type of the head entry.
REQ-011 SHALL have port m_valid, output, 1 bit: head entry valid.
REQ-012 SHALL have port m_ready, input, 1 bit: the downstream AES core consumes the head entry.
REQ-013 SHALL have port level, output, $clog2(DEPTH+1) bits: number of stored blocks.
REQ-014 SHALL have port mix_err, output, 1 bit: sticky flag for a key/data mix inside one block.

Function
REQ-015 SHALL count a word as accepted only on a cycle where s_valid && s_ready.
REQ-016 SHALL pack words big-endian: word 0 goes to [127:96], word 1 to [95:64], word 2 to [63:32], word 3 to [31:0].
REQ-017 SHALL keep a 2-bit word counter, wcnt (0..3); each accepted word increments it; acceptance at wcnt=3 wraps it to 0 and writes the block into the buffer.
REQ-018 SHALL use the s_key value of word 0 as the block type; the block SHALL be stored with that type.
REQ-019 SHALL compare s_key on words 1..3 against the latched type; on a mismatch it SHALL set mix_err, discard the partial block (wcnt to 0, word not stored) and write nothing to the buffer.
REQ-020 SHALL drive s_ready = (wcnt != 3) || (level < DEPTH); s_ready SHALL NOT combinationally depend on m_ready.
REQ-021 SHALL drive m_valid = (level != 0); m_data and m_key SHALL be the head entry, from registers with no combinational path from the s_* inputs.
REQ-022 SHALL pop the head on a cycle where m_valid && m_ready.
REQ-023 SHALL apply push and pop in the same cycle together: level unchanged, FIFO order preserved.
REQ-024 SHALL have a latency of one cycle: when word 3 is accepted at edge N into an empty buffer, m_valid SHALL be 1 after edge N.
REQ-025 SHALL wrap the read and write pointers modulo DEPTH; the buffer SHALL never overwrite or re-emit an entry.
REQ-026 SHALL apply s_flush with priority over a word accepted in the same cycle: wcnt goes to 0 and that word is dropped.
REQ-027 SHALL NOT let s_flush affect buffered blocks, level, or mix_err.
REQ-028 SHALL hold m_data and m_key stable while m_valid && !m_ready.
REQ-029 SHALL hold mix_err at 1 until reset.

Reset
REQ-030 SHALL, while rst_n = 0, immediately force wcnt = 0, pointers = 0, level = 0, m_valid = 0, mix_err = 0, m_key = 0, m_data = 0, and s_ready = 1.
REQ-031 SHALL discard a reset asserted mid-block or with a non-empty buffer (partial and stored blocks lost); after release the first accepted word is word 0.
REQ-032 SHALL require the buffer storage array to need no reset beyond the pointers.

Verification
REQ-033 SHALL cover single key block: after reset, words 2b7e1516, 28aed2a6, abf71588, 09cf4f3c with s_key=1 and m_ready=1 -> one cycle after word 3, m_valid=1, m_key=1, m_data=2b7e151628aed2a6abf7158809cf4f3c; popped the same cycle.
REQ-034 SHALL cover back-pressure: DEPTH=2, m_ready=0, three data blocks streamed -> level=2; s_ready=0 only at wcnt=3 of block 3; raising m_ready for 1 cycle -> s_ready=1 and block 3 stored; output order is 1, 2, 3.
REQ-035 SHALL cover simultaneous push/pop: level=1 and m_ready=1 in the cycle word 3 is accepted -> level stays 1 and the next head is the new block.
REQ-036 SHALL cover key/data mix: word 0 s_key=1, word 1 s_key=0 -> mix_err=1, level unchanged, next 4 words form a complete new block.
REQ-037 SHALL cover flush: s_flush asserted with the 3rd word valid -> that word is dropped, wcnt=0, the buffered block is still output intact.
REQ-038 SHALL cover reset mid-operation: rst_n low asynchronously with level=2, wcnt=2 -> all outputs take REQ-030 values before the next clk edge.
